alu_arbiter: RTL and testbench

Sequencer and arbiter that shares the single combinational ALU between two requesters, for example the execute stage and an address/branch-compare unit. It accepts one operation at a time through a valid/ready handshake and drives the shared ALU from registered operands. It captures the result and zero flag, then returns them to the granted requester with a response handshake. It sits between the requesters and the `alu` instance and owns that instance's `a_i`/`b_i`/`alu_op_i` inputs.

---
 rtl/alu_arb_pkg.sv | 32 +++
 rtl/arb_sel2.sv | 41 ++++
 rtl/alu_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, ALU opcode encodings and default widths used by
// alu_arbiter, arb_sel2 and anything that talks to the shared ALU.
package alu_arb_pkg;

    // Default operand/result and opcode widths.
    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 3;

    // Sequencer states: one operation in flight at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Opcode encodings understood by the shared ALU. The arbiter passes the
    // opcode through untouched; these are here so requesters and benches
    // agree on the encoding.
    localparam logic [OP_W_DEF-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W_DEF-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W_DEF-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W_DEF-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W_DEF-1:0] ALU_XOR = 3'b100;
    localparam logic [OP_W_DEF-1:0] ALU_SLL = 3'b101;
    localparam logic [OP_W_DEF-1:0] ALU_SRL = 3'b110;
    localparam logic [OP_W_DEF-1:0] ALU_SRA = 3'b111;

endpackage

// File: rtl/arb_sel2.sv
// Two-way grant selector feeding the alu_arbiter accept logic.
// Latency: zero, purely combinational from the valids (and last grant).
// Backpressure: none; the caller gates the grant with its own idle state.
//
// Ports:
//   valid0_i, valid1_i  requests from requester 0 / 1
//   last_grant_i        most recent winner (present only with ALU_ARB_RR_EN)
//   gnt0_o, gnt1_o      one-hot grant, both low when nothing is requesting
//
// Build option: ALU_ARB_RR_EN selects round-robin on contention; without it
// requester 0 always wins contention (fixed priority).
module arb_sel2
    import alu_arb_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
`ifdef ALU_ARB_RR_EN
    input  logic last_grant_i,
`endif
    output logic gnt0_o,
    output logic gnt1_o
);

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (valid0_i && valid1_i) begin
`ifdef ALU_ARB_RR_EN
            // The requester that did not win last time goes now.
            gnt0_o = last_grant_i;
            gnt1_o = ~last_grant_i;
`else
            gnt0_o = 1'b1;
`endif
        end else begin
            gnt0_o = valid0_i;
            gnt1_o = valid1_i;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one op at a time.
// Latency: accept in cycle N, ALU driven in N+1, response valid from N+2.
// Backpressure: req ready only in IDLE; response held until rsp ready, no timeout.
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   reqN_valid_i/ready_o/a_i/b_i/op_i    request handshake + operands, N=0,1
//   rspN_valid_o/ready_i/result_o/zero_o response handshake + captured result
//   alu_a_o/b_o/op_o                     registered operands to the shared ALU
//   alu_result_i/zero_i                  shared ALU outputs, captured in EXEC
//   busy_o                               high whenever the sequencer is not idle
//
// Build option: ALU_ARB_RR_EN enables round-robin arbitration with a
// last-grant register; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic [OP_W-1:0]   req0_op_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    input  logic [OP_W-1:0]   req1_op_i,

    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_result_o,
    output logic              rsp0_zero_o,

    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_result_o,
    output logic              rsp1_zero_o,

    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,

    output logic              busy_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e        state_q,  state_d;
    logic              grant_q,  grant_d;     // owner of the op in flight
`ifdef ALU_ARB_RR_EN
    logic              last_grant_q, last_grant_d;
`endif
    logic [DATA_W-1:0] a_q,      a_d;
    logic [DATA_W-1:0] b_q,      b_d;
    logic [OP_W-1:0]   op_q,     op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q,   zero_d;
    logic [1:0]        rsp_vld_q, rsp_vld_d;  // bit N = rspN_valid_o
    logic              busy_q,   busy_d;

    // ------------------------------------------------------------------
    // Arbitration and accept
    // ------------------------------------------------------------------
    logic gnt0;
    logic gnt1;
    logic in_idle;
    logic acc_vld;
    logic acc_idx;
    logic rsp_take;

    arb_sel2 u_sel (
        .valid0_i     (req0_valid_i),
        .valid1_i     (req1_valid_i),
`ifdef ALU_ARB_RR_EN
        .last_grant_i (last_grant_q),
`endif
        .gnt0_o       (gnt0),
        .gnt1_o       (gnt1)
    );

    // Ready is combinational from the valids so a requester is accepted in
    // the very cycle it presents, provided the sequencer is idle.
    assign in_idle      = (state_q == IDLE);
    assign req0_ready_o = in_idle & gnt0;
    assign req1_ready_o = in_idle & gnt1;

    // The selector only grants a valid requester, so ready implies valid.
    assign acc_vld  = req0_ready_o | req1_ready_o;
    assign acc_idx  = gnt1;

    // Only the owner's ready can retire the response.
    assign rsp_take = grant_q ? rsp1_ready_i : rsp0_ready_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
`ifdef ALU_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        rsp_vld_d = rsp_vld_q;

        unique case (state_q)
            IDLE: begin
                if (acc_vld) begin
                    state_d = EXEC;
                    grant_d = acc_idx;
`ifdef ALU_ARB_RR_EN
                    last_grant_d = acc_idx;
`endif
                    a_d  = acc_idx ? req1_a_i  : req0_a_i;
                    b_d  = acc_idx ? req1_b_i  : req0_b_i;
                    op_d = acc_idx ? req1_op_i : req0_op_i;
                end
            end
            EXEC: begin
                // Operand registers have driven the ALU for a full cycle;
                // its outputs are settled and can be captured.
                state_d   = RESP;
                result_d  = alu_result_i;
                zero_d    = alu_zero_i;
                rsp_vld_d = grant_q ? 2'b10 : 2'b01;
            end
            RESP: begin
                if (rsp_take) begin
                    state_d   = IDLE;
                    rsp_vld_d = 2'b00;
                end
            end
            default: begin
                state_d   = IDLE;
                rsp_vld_d = 2'b00;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
`ifdef ALU_ARB_RR_EN
            // Requester 0 wins the first contention after reset.
            last_grant_q <= 1'b1;
`endif
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            rsp_vld_q    <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            rsp_vld_q    <= rsp_vld_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Operand registers hold their last values outside EXEC so the ALU
    // inputs do not toggle needlessly between operations.
    assign alu_a_o  = a_q;
    assign alu_b_o  = b_q;
    assign alu_op_o = op_q;

    // Result and zero are shared; only the valid is steered by the grant.
    assign rsp0_valid_o  = rsp_vld_q[0];
    assign rsp1_valid_o  = rsp_vld_q[1];
    assign rsp0_result_o = result_q;
    assign rsp1_result_o = result_q;
    assign rsp0_zero_o   = zero_q;
    assign rsp1_zero_o   = zero_q;

    assign busy_o = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic.
// Latency: n/a (bench).
// Backpressure: randomised response ready during the random phase.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int DW = 32;
    localparam int OW = 3;

    typedef struct {
        int            idx;
        logic [DW-1:0] res;
        logic          zero;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
    logic [DW-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic [OW-1:0] req0_op_i, req1_op_i;
    logic          rsp0_valid_o, rsp1_valid_o, rsp0_ready_i, rsp1_ready_i;
    logic [DW-1:0] rsp0_result_o, rsp1_result_o;
    logic          rsp0_zero_o, rsp1_zero_o;
    logic [DW-1:0] alu_a_o, alu_b_o, alu_result_i;
    logic [OW-1:0] alu_op_o;
    logic          alu_zero_i, busy_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    int   gnt_log[$];
    bit   outstanding = 1'b0;
    bit   last_grant  = 1'b1;
    int   acc_cyc = -10;
    int   acc_idx = 0;
    logic [DW-1:0] acc_a, acc_b;
    logic [OW-1:0] acc_op;
    bit   rand_rsp = 1'b0;

    always #5 clk_i = ~clk_i;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_op_i(req0_op_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_op_i(req1_op_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp0_result_o(rsp0_result_o), .rsp0_zero_o(rsp0_zero_o),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
        .rsp1_result_o(rsp1_result_o), .rsp1_zero_o(rsp1_zero_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .busy_o(busy_o)
    );

    // Behavioural shared ALU; also the reference for expected results.
    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            default: return $signed(a) >>> b[4:0];
        endcase
    endfunction

    assign alu_result_i = alu_fn(alu_op_o, alu_a_o, alu_b_o);
    assign alu_zero_i   = (alu_result_i == '0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic drive(input int idx, input logic v, input logic [OW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (idx == 0) begin
            req0_valid_i = v; req0_op_i = op; req0_a_i = a; req0_b_i = b;
        end else begin
            req1_valid_i = v; req1_op_i = op; req1_a_i = a; req1_b_i = b;
        end
    endtask

    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    // Present one op and hold it until accepted; returns just after the accept edge.
    task automatic issue(input int idx, input logic [OW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        int t;
        bit ok;
        drive(idx, 1'b1, op, a, b);
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 300) begin
            @(negedge clk_i);
            t++;
            ok = !rst_i && ((idx == 0) ? req0_ready_o : req1_ready_o);
        end
        chk($sformatf("accept_req%0d", idx), {63'd0, ok}, 64'd1);
        sync();
        drive(idx, 1'b0, op, a, b);
    endtask

    task automatic wait_rsp(input int idx);
        int t;
        bit seen;
        t    = 0;
        seen = 1'b0;
        while (!seen && t < 50) begin
            @(negedge clk_i);
            t++;
            seen = (idx == 0) ? rsp0_valid_o : rsp1_valid_o;
        end
        chk($sformatf("rsp%0d_arrives", idx), {63'd0, seen}, 64'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (outstanding && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        chk("drain", {63'd0, outstanding}, 64'd0);
    endtask

    task automatic rand_driver(input int idx, input int n);
        logic [DW-1:0] a, b;
        logic [OW-1:0] op;
        for (int k = 0; k < n; k++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            op = OW'($urandom_range(0, 7));
            issue(idx, op, a, b);
            repeat ($urandom_range(0, 2)) sync();
        end
    endtask

    // Scoreboard / monitor. Inputs change just after posedge, so at negedge
    // valid&ready describes the handshake that the next posedge completes.
    always @(negedge clk_i) begin : mon
        int   pick;
        bit   er0, er1;
        exp_t e;
        cyc++;
        if (rst_i) begin
            exp_q.delete();
            outstanding = 1'b0;
            last_grant  = 1'b1;
            acc_cyc     = -10;
        end else begin
`ifdef ALU_ARB_RR_EN
            pick = (req0_valid_i && req1_valid_i) ? (last_grant ? 0 : 1)
                                                  : (req1_valid_i ? 1 : 0);
`else
            pick = req0_valid_i ? 0 : 1;
`endif
            er0 = !outstanding && req0_valid_i && (pick == 0);
            er1 = !outstanding && req1_valid_i && (pick == 1);
            chk("req_ready", {62'd0, req1_ready_o, req0_ready_o}, {62'd0, er1, er0});
            chk("busy", {63'd0, busy_o}, {63'd0, outstanding});

            if (cyc == acc_cyc + 1) begin
                chk("exec_alu_a", alu_a_o, acc_a);
                chk("exec_alu_b", alu_b_o, acc_b);
                chk("exec_alu_op", alu_op_o, acc_op);
                chk("exec_no_rsp", {rsp1_valid_o, rsp0_valid_o}, 2'b00);
            end
            if (cyc == acc_cyc + 2)
                chk("resp_at_n2", {rsp1_valid_o, rsp0_valid_o}, (acc_idx == 1) ? 2'b10 : 2'b01);

            if (rsp0_valid_o || rsp1_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {rsp1_valid_o, rsp0_valid_o}, 2'b00);
                end else begin
                    e = exp_q[0];
                    chk("rsp_steer", {rsp1_valid_o, rsp0_valid_o}, (e.idx == 1) ? 2'b10 : 2'b01);
                    chk("rsp0_result", rsp0_result_o, e.res);
                    chk("rsp1_result", rsp1_result_o, e.res);
                    chk("rsp_zero", {rsp1_zero_o, rsp0_zero_o}, {e.zero, e.zero});
                    if ((e.idx == 0) ? rsp0_ready_i : rsp1_ready_i) begin
                        void'(exp_q.pop_front());
                        outstanding = 1'b0;
                    end
                end
            end

            if ((req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o)) begin
                acc_idx = (req1_valid_i && req1_ready_o) ? 1 : 0;
                acc_a   = (acc_idx == 1) ? req1_a_i  : req0_a_i;
                acc_b   = (acc_idx == 1) ? req1_b_i  : req0_b_i;
                acc_op  = (acc_idx == 1) ? req1_op_i : req0_op_i;
                e.idx   = acc_idx;
                e.res   = alu_fn(acc_op, acc_a, acc_b);
                e.zero  = (e.res == '0);
                exp_q.push_back(e);
                gnt_log.push_back(acc_idx);
                outstanding = 1'b1;
                last_grant  = acc_idx[0];
                acc_cyc     = cyc;
            end
        end
    end

    initial begin : main
        bit d0, d1;
        int t;
        int exp_g[4];

        rst_i = 1'b1;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        rsp0_ready_i = 1'b1;
        rsp1_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset values
        @(negedge clk_i);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_rsp_valid", {rsp1_valid_o, rsp0_valid_o}, 2'b00);
        chk("rst_alu_a", alu_a_o, 32'd0);
        chk("rst_alu_b", alu_b_o, 32'd0);
        chk("rst_alu_op", alu_op_o, 3'd0);
        chk("rst_result", rsp0_result_o, 32'd0);
        chk("rst_zero", {rsp1_zero_o, rsp0_zero_o}, 2'b00);

        // ADD from requester 0
        sync();
        issue(0, ALU_ADD, 32'd5, 32'd3);
        wait_rsp(0);
        chk("add_result", rsp0_result_o, 32'd8);
        chk("add_zero", {63'd0, rsp0_zero_o}, 64'd0);
        chk("add_rsp1_quiet", {63'd0, rsp1_valid_o}, 64'd0);

        // SUB from requester 1, zero result
        sync();
        issue(1, ALU_SUB, 32'd5, 32'd5);
        @(negedge clk_i);
        chk("sub_exec_op", alu_op_o, 3'b001);
        wait_rsp(1);
        chk("sub_result", rsp1_result_o, 32'd0);
        chk("sub_zero", {63'd0, rsp1_zero_o}, 64'd1);

        // Continuous contention
        sync();
        gnt_log.delete();
        fork
            begin
                issue(0, ALU_AND, 32'hFF00FF00, 32'h00FF00FF);
                issue(0, ALU_AND, 32'hFF00FF00, 32'h00FF00FF);
            end
            begin
                issue(1, ALU_OR, 32'hFF00FF00, 32'h00FF00FF);
                issue(1, ALU_OR, 32'hFF00FF00, 32'h00FF00FF);
            end
        join
        drain();
`ifdef ALU_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 1, 1};
`endif
        chk("contend_count", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_log.size())
                chk($sformatf("contend_grant%0d", i), gnt_log[i], exp_g[i]);

        // SRA with response stalled; requester 1 waits meanwhile
        sync();
        rsp0_ready_i = 1'b0;
        d1 = 1'b0;
        issue(0, ALU_SRA, 32'h80000000, 32'd2);
        fork
            begin
                issue(1, ALU_ADD, 32'd1, 32'd1);
                d1 = 1'b1;
            end
        join_none
        wait_rsp(0);
        repeat (5) begin
            @(negedge clk_i);
            chk("stall_valid", {63'd0, rsp0_valid_o}, 64'd1);
            chk("stall_result", rsp0_result_o, 32'hE0000000);
            chk("stall_no_accept", {req1_ready_o, req0_ready_o}, 2'b00);
        end
        sync();
        rsp0_ready_i = 1'b1;
        t = 0;
        while (!d1 && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        chk("stall_req1_done", {63'd0, d1}, 64'd1);
        drain();

        // Reset during EXEC
        sync();
        issue(0, ALU_SLL, 32'd1, 32'd2);
        rst_i = 1'b1;
        sync();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
        chk("mid_rst_rsp", {rsp1_valid_o, rsp0_valid_o}, 2'b00);
        chk("mid_rst_alu_a", alu_a_o, 32'd0);
        chk("mid_rst_alu_b", alu_b_o, 32'd0);
        chk("mid_rst_alu_op", alu_op_o, 3'd0);
        chk("mid_rst_result", rsp0_result_o, 32'd0);
        repeat (3) begin
            @(negedge clk_i);
            chk("mid_rst_no_rsp", {rsp1_valid_o, rsp0_valid_o}, 2'b00);
        end

        // XOR from requester 1; operands persist afterwards
        sync();
        issue(1, ALU_XOR, 32'hFF00FF00, 32'h00FF00FF);
        wait_rsp(1);
        chk("xor_result", rsp1_result_o, 32'hFFFFFFFF);
        chk("xor_zero", {63'd0, rsp1_zero_o}, 64'd0);
        @(negedge clk_i);
        chk("xor_alu_a_held", alu_a_o, 32'hFF00FF00);
        chk("xor_idle", {63'd0, busy_o}, 64'd0);

        // Random traffic with random response backpressure
        sync();
        d0 = 1'b0;
        d1 = 1'b0;
        rand_rsp = 1'b1;
        fork
            begin rand_driver(0, 30); d0 = 1'b1; end
            begin rand_driver(1, 30); d1 = 1'b1; end
            begin
                while (rand_rsp) begin
                    sync();
                    if (rand_rsp) begin
                        rsp0_ready_i = 1'($urandom_range(0, 1));
                        rsp1_ready_i = 1'($urandom_range(0, 1));
                    end
                end
            end
        join_none
        t = 0;
        while (!(d0 && d1) && t < 8000) begin
            @(negedge clk_i);
            t++;
        end
        chk("random_done", {62'd0, d1, d0}, 2'b11);
        rand_rsp = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        rsp0_ready_i = 1'b1;
        rsp1_ready_i = 1'b1;
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
